// File: rtl/csa_accum_ctrl.sv
// Carry-save multi-operand accumulator sequencer: one 3:2 compression per accepted operand, one resolve add, result held on valid/ready.
// out_valid rises 2 cycles after the last operand is accepted; result held until out_ready. Optional saturation: CSA_SAT_EN.
module csa_accum_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 8,
  parameter int ACC_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [$clog2(MAX_OPS):0]   num_ops_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ACC_W-1:0]           out_sum_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int NW = $clog2(MAX_OPS) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  s_q, s_d;
  logic [ACC_W-1:0]  c_q, c_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [NW-1:0]     nops_q, nops_d;
  logic              err_q, err_d;
  logic [ACC_W-1:0]  d_ext;
  logic [ACC_W-2:0]  maj_lo;
  logic              nops_legal;
`ifdef CSA_SAT_EN
  logic              ovf_q, ovf_d;
  logic              maj_msb;
  logic [ACC_W:0]    res_w;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      nops_q  <= '0;
      err_q   <= 1'b0;
`ifdef CSA_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      nops_q  <= nops_d;
      err_q   <= err_d;
`ifdef CSA_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    c_d        = c_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    nops_d     = nops_q;
    err_d      = 1'b0;
    d_ext      = {{(ACC_W-WIDTH){1'b0}}, in_data_i};
    nops_legal = (num_ops_i != '0) && (num_ops_i <= NW'(MAX_OPS));
    // The carry vector shifts left, so only the low ACC_W-1 majority bits survive.
    maj_lo     = (s_q[ACC_W-2:0] & c_q[ACC_W-2:0]) |
                 (s_q[ACC_W-2:0] & d_ext[ACC_W-2:0]) |
                 (c_q[ACC_W-2:0] & d_ext[ACC_W-2:0]);
`ifdef CSA_SAT_EN
    ovf_d      = ovf_q;
    maj_msb    = (s_q[ACC_W-1] & c_q[ACC_W-1]) |
                 (s_q[ACC_W-1] & d_ext[ACC_W-1]) |
                 (c_q[ACC_W-1] & d_ext[ACC_W-1]);
    res_w      = {1'b0, s_q} + {1'b0, c_q};
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (nops_legal) begin
            state_d = ACCUM;
            nops_d  = num_ops_i;
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
`ifdef CSA_SAT_EN
            ovf_d   = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (in_valid_i) begin
          s_d   = s_q ^ c_q ^ d_ext;
          c_d   = {maj_lo, 1'b0};
          cnt_d = cnt_q + NW'(1);
`ifdef CSA_SAT_EN
          ovf_d = ovf_q | maj_msb;
`endif
          if (cnt_q == nops_q - NW'(1)) begin
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
`ifdef CSA_SAT_EN
        ovf_d = ovf_q | res_w[ACC_W];
        sum_d = (ovf_q | res_w[ACC_W]) ? {ACC_W{1'b1}} : res_w[ACC_W-1:0];
`else
        sum_d = s_q + c_q;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == ACCUM);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign out_sum_o   = sum_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Bench for csa_accum_ctrl: a default instance and an ACC_W=5 instance share all inputs; sums checked against plain arithmetic.
module tb_csa_accum_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] num_ops;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;
  logic       in_ready, out_valid, busy, err;
  logic [6:0] out_sum;
  logic       b_in_ready, b_out_valid, b_busy, b_err;
  logic [4:0] b_out_sum;

  int tests = 0;
  int fails = 0;
  int ops_q[$];

  always #5 clk = ~clk;

  csa_accum_ctrl #(.WIDTH(4), .MAX_OPS(8), .ACC_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .num_ops_i(num_ops),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sum_o(out_sum),
    .busy_o(busy), .err_o(err)
  );

  csa_accum_ctrl #(.WIDTH(4), .MAX_OPS(8), .ACC_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .num_ops_i(num_ops),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_sum_o(b_out_sum),
    .busy_o(b_busy), .err_o(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref5(input int tot);
`ifdef CSA_SAT_EN
    return (tot > 31) ? 31 : tot;
`else
    return tot % 32;
`endif
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vld"}, out_valid, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_b_busy"}, b_busy, 0);
  endtask

  // gap: 0 none, 1 every other cycle, 2 random
  task automatic run_job(input string tag, input int gap, input int hold);
    int n, i, tot, budget, cyc;
    logic rdy;
    n = ops_q.size();
    i = 0; tot = 0; cyc = 0;
    budget = 4 * n + 20;
    @(negedge clk);
    start = 1'b1; num_ops = 4'(n);
    @(negedge clk);
    start = 1'b0; num_ops = 4'($urandom);
    chk({tag, "_busy"}, busy, 1);
    while (i < n && budget > 0) begin
      chk({tag, "_in_rdy"}, in_ready, 1);
      chk({tag, "_b_in_rdy"}, b_in_ready, 1);
      rdy = in_ready;
      if ((gap == 1 && cyc[0]) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_data  = 4'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = 4'(ops_q[i]);
      end
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && rdy) begin
        tot += ops_q[i];
        i++;
      end
      cyc++;
      budget--;
    end
    in_valid = 1'b0; start = 1'b0;
    chk({tag, "_ops_taken"}, i, n);
    chk({tag, "_resolve_vld"}, out_valid, 0);
    chk({tag, "_resolve_rdy"}, in_ready, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, tot % 128);
    chk({tag, "_b_sum"}, b_out_sum, ref5(tot));
    for (int k = 0; k < hold; k++) begin
      start = 1'b1; num_ops = 4'd2;
      @(negedge clk);
      chk({tag, "_hold_vld"}, out_valid, 1);
      chk({tag, "_hold_sum"}, out_sum, tot % 128);
    end
    out_ready = 1'b1;
    start = (hold > 0);
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    chk_idle({tag, "_accept"});
    chk({tag, "_sum_kept"}, out_sum, tot % 128);
    @(negedge clk);
    chk_idle({tag, "_after"});
  endtask

  task automatic err_case(input string tag, input int v);
    @(negedge clk);
    start = 1'b1; num_ops = 4'(v);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_err"}, err, 1);
    chk({tag, "_b_err"}, b_err, 1);
    chk({tag, "_busy"}, busy, 0);
    @(negedge clk);
    chk({tag, "_err_clr"}, err, 0);
    chk_idle(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_ops = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_sum", out_sum, 0);
    chk("rst_err", err, 0);
    chk_idle("rst");
    @(negedge clk);
    rst_n = 1'b1;

    ops_q = '{5, 9, 15};
    run_job("t1", 0, 0);

    ops_q = '{15, 15, 15, 15, 15, 15, 15, 15};
    run_job("t2", 1, 0);

    err_case("t3_zero", 0);
    err_case("t3_nine", 9);

    ops_q = '{2, 3};
    run_job("t4", 0, 5);

    // Abort a 4-operand job after two transfers.
    @(negedge clk);
    start = 1'b1; num_ops = 4'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 4'd7;
    @(negedge clk);
    in_data = 4'd6;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("t5_rst_sum", out_sum, 0);
    chk("t5_rst_err", err, 0);
    chk_idle("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ops_q = '{1, 1};
    run_job("t5_job", 0, 0);

    ops_q = '{15, 15, 15};
    run_job("t6", 0, 0);

    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(1, 8);
      ops_q.delete();
      for (int k = 0; k < n; k++) ops_q.push_back($urandom_range(0, 15));
      run_job("rnd", 2, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) err_case("rnd_err", ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
